fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the FIFO read data and stream data.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-004 Port fifo_empty, input, 1 bit, SHALL be the FIFO empty flag.
REQ-005 Port fifo_rd_en, output, 1 bit, SHALL be the FIFO read request; FIFO registers the word on the same edge.
REQ-006 Port fifo_data, input, DATA_WIDTH, SHALL carry the FIFO word, valid in the cycle after an accepted fifo_rd_en.
REQ-007 Port m_valid, output, 1 bit, SHALL indicate m_data holds a valid word.
REQ-008 Port m_ready, input, 1 bit, SHALL indicate the downstream sink accepts m_data.
REQ-009 Port m_data, output, DATA_WIDTH, SHALL be the stream data word.
REQ-010 Port xfer_cnt, output, 16 bits, SHALL be present only when FIFO_RD_STREAM_CNT_EN is defined (REQ-025).

Function
REQ-011 Block SHALL convert the FIFO read port (1-cycle read latency) into a valid/ready stream with no loss, duplication or reordering.
REQ-012 Internal storage SHALL be a 2-entry buffer (head/tail pointers, 2-bit count 0..2) plus a 1-bit in-flight flag.
REQ-013 pop SHALL equal m_valid & m_ready; a word transfers only on such a cycle.
REQ-014 fifo_rd_en SHALL be combinational: !fifo_empty & !rst & (count + inflight - pop < 2).
REQ-015 inflight SHALL be set on the edge where fifo_rd_en is 1 and cleared otherwise.
REQ-016 When inflight is 1, fifo_data SHALL be written to the tail entry on that edge.
REQ-017 m_valid SHALL be 1 exactly when count != 0; m_data SHALL be the head entry, held stable while m_valid & !m_ready.
REQ-018 Simultaneous capture and pop SHALL leave count unchanged; pointers wrap modulo 2.
REQ-019 Latency: FIFO non-empty in cycle 0 with block idle -> fifo_rd_en cycle 0, capture end of cycle 1, m_valid cycle 2.
REQ-020 With m_ready held 1 and FIFO continuously non-empty, throughput SHALL be one word per cycle after the first.
REQ-021 With m_ready 0, at most 2 words SHALL be read; fifo_rd_en SHALL stay 0 until a pop frees a slot.
REQ-022 count SHALL never exceed 2; a capture into a full buffer is a design error (assertion).

Reset
REQ-023 On rst: count, pointers, inflight = 0; m_valid = 0; fifo_rd_en = 0; xfer_cnt = 0; buffer contents not reset; an in-flight FIFO word is discarded.
REQ-024 Reset mid-transfer SHALL take effect next edge with no m_valid pulse in the following cycle.

Configuration
REQ-025 Macro FIFO_RD_STREAM_CNT_EN defined: xfer_cnt increments by 1 per pop, wraps 0xFFFF->0x0000, cleared by rst; undefined: port and counter absent, other behaviour identical.

Structure
REQ-026 Shared package fifo_pkg SHALL hold DATA_WIDTH default, buffer depth constant (2) and counter width (16).
REQ-027 The 2-entry buffer SHALL be sub-module fifo_rd_skid (push, pop, data in/out, count out); pointer/credit logic stays top-level.

Verification
REQ-028 FIFO holds 0x11, m_ready=1 from reset release -> fifo_rd_en cycle 0, m_valid/m_data=0x11 cycle 2, single pulse.
REQ-029 FIFO holds 0x01..0x08, m_ready=1 -> 8 consecutive beats 0x01..0x08, no gaps after first; xfer_cnt=8 (macro on).
REQ-030 FIFO holds 5 words, m_ready=0 -> exactly 2 fifo_rd_en pulses, m_data=first word held; release m_ready -> remaining 3 read in order.
REQ-031 m_ready toggling 1/0 each cycle over 16 words -> all 16 delivered in order, count never >2.
REQ-032 rst asserted in cycle after fifo_rd_en -> in-flight word dropped, m_valid=0 next cycle, xfer_cnt=0.
REQ-033 Macro on, 65537 pops -> xfer_cnt=0x0001.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO-read-to-stream block.
// The optional transfer counter is enabled by defining FIFO_RD_STREAM_CNT_EN.
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int BUF_DEPTH      = 2;
  localparam int CNT_W          = 16;

  // A read may be issued only if the word it returns is guaranteed a free slot.
  function automatic logic has_room(input logic [1:0] cnt, input logic infl, input logic pop);
    return ({1'b0, cnt} + {2'b00, infl} - {2'b00, pop}) < 3'(BUF_DEPTH);
  endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream bundle.
// master = the converter block, slave = the FIFO/sink environment.
interface fifo_rd_stream_if #(parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (input fifo_empty, fifo_data, m_ready, output fifo_rd_en, m_valid, m_data);
  modport slave  (output fifo_empty, fifo_data, m_ready, input fifo_rd_en, m_valid, m_data);
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry circular buffer absorbing FIFO words already in flight when the sink stalls.
// Storage is intentionally not reset; only pointers and count are.
module fifo_rd_skid import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            count_o
);
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            count_q, count_d;

  always_comb begin
    head_d  = head_q ^ pop_i;
    tail_d  = tail_q ^ push_i;
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !rst) mem_q[tail_q] <= data_i;
  end

  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && count_q == 2'd2));
  a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);
endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a 1-cycle-latency FIFO read port into a valid/ready stream.
// FIFO_RD_STREAM_CNT_EN adds a 16-bit wrapping transfer counter output xfer_cnt.
module fifo_rd_stream import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  fifo_rd_stream_if.master bus
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);
  logic                  inflight_q, inflight_d;
  logic                  pop;
  logic                  rd_en;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] head_data;

  assign pop   = bus.m_valid & bus.m_ready;
  // Credit check counts the word still in flight so a stall never overfills the buffer.
  assign rd_en = !bus.fifo_empty & !rst & has_room(count, inflight_q, pop);

  always_comb inflight_d = rd_en;

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= inflight_d;
  end

  fifo_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .pop_i  (pop),
    .data_i (bus.fifo_data),
    .data_o (head_data),
    .count_o(count)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (count != 2'd0);
  assign bus.m_data     = head_data;

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_W-1:0] xfer_q, xfer_d;

  always_comb begin
    xfer_d = xfer_q;
    if (pop) xfer_d = xfer_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) xfer_q <= '0;
    else     xfer_q <= xfer_d;
  end

  assign xfer_cnt = xfer_q;
`endif
endmodule
